sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM read master that sequences a boot-time check of the system-ID slave.
- On a start pulse it reads word 0 (system ID), then word 1 (build timestamp).
- It compares both words against expected values and reports match/mismatch/timeout flags.
- It sits between the reset controller / CPU boot logic and the system-ID slave's control port. Its verdict gates software start or lights a status LED.

Parameters:
- EXPECTED_ID, 32'h0000_0000, system ID value the hardware must return at address 0.
- EXPECTED_TS, 32'd1361149627, build timestamp the hardware must return at address 1.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest cycles tolerated per read (1..65535).
- MAX_RETRY, 2, extra full check attempts after a failure (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; deasserted synchronously to clock upstream.
- start  in  1  one-cycle request; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the verdict is valid.
- id_ok  out  1  held: last captured ID equals EXPECTED_ID.
- ts_ok  out  1  held: last captured timestamp equals EXPECTED_TS.
- timeout  out  1  held: last check aborted on timeout.
- id_value  out  32  held: last captured word 0.
- ts_value  out  32  held: last captured word 1.
- avm_address  out  1  word address to the slave.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall; tie 0 for the zero-wait system-ID slave.
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest (zero read latency).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: every output register is 0 (busy, done, id_ok, ts_ok, timeout, id_value, ts_value, avm_read, avm_address). FSM goes to IDLE and counters clear.
- FSM states: IDLE, RD_ID, RD_TS, CHECK, REPORT.
  - IDLE: start=1 goes to RD_ID. Entering RD_ID clears id_ok, ts_ok and timeout, and sets busy.
  - RD_ID: avm_read=1, avm_address=0.
    - When !avm_waitrequest, capture id_value and go to RD_TS.
    - Otherwise increment wait_cnt. When wait_cnt reaches TIMEOUT_CYCLES, set timeout and go to REPORT.
  - RD_TS: as RD_ID with address 1, capturing ts_value, then go to CHECK. wait_cnt clears on entry.
  - CHECK: register id_ok = (id_value==EXPECTED_ID) and ts_ok = (ts_value==EXPECTED_TS), then go to REPORT.
  - REPORT: done=1 for exactly this cycle, busy drops the same cycle, then go to IDLE.
- Read strobe: avm_read and avm_address are registered outputs and are stable while waitrequest is high.
- Latency with waitrequest=0:
  - start sampled at edge N.
  - avm_read high at N+1 (addr 0) and N+2 (addr 1).
  - CHECK at N+3.
  - done pulse at N+4.
  - Each waitrequest cycle adds one cycle.
- Start handling: start in any non-IDLE state is dropped (not queued). start coincident with done is also dropped.
- Timeout boundary: TIMEOUT_CYCLES=1 means a single waitrequest cycle aborts. On timeout id_ok=ts_ok=0. Captured values not yet read keep their previous contents.
- Reset mid-read: avm_read drops asynchronously and no partial verdict is reported.

Optional Feature:
- Macro: SYSID_CHECKER_RETRY_EN.
- Defined:
  - On a mismatch or timeout in CHECK/abort, if retry_cnt < MAX_RETRY, increment retry_cnt and return to RD_ID without pulsing done. busy stays high.
  - The final verdict reflects the last attempt.
  - Extra output retries[1:0] (saturating) reports attempts used. It resets to 0 and clears on a new start.
- Undefined: single attempt, no retries port, MAX_RETRY unused.

Decomposition:
- Package sysid_checker_pkg holds:
  - the state enum encoding (IDLE=0..REPORT=4, 3 bits);
  - ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - the default EXPECTED_* constants;
  - the timeout counter width function (clog2 of TIMEOUT_CYCLES+1).
- One natural sub-module, sysid_checker_rd: a single-word Avalon read engine with its timeout counter. It is instantiated once and reused per word by the FSM.

Test Plan:
- Zero-wait slave returning 0 / 1361149627; start pulse → done at start+4; id_ok=1, ts_ok=1, timeout=0; id_value=0, ts_value=1361149627.
- Slave returns ts 1361149628 → done at start+4, id_ok=1, ts_ok=0, ts_value=1361149628.
- waitrequest held 3 cycles on word 1, TIMEOUT_CYCLES=255 → done at start+7, both ok=1; avm_address held at 1 throughout the stall.
- waitrequest stuck high, TIMEOUT_CYCLES=4 → timeout=1, id_ok=ts_ok=0, done 5 cycles after start+1; second start while busy ignored.
- reset_n asserted during RD_TS → avm_read and all flags 0 immediately; no done pulse; after release, a fresh start completes normally.
- With SYSID_CHECKER_RETRY_EN, MAX_RETRY=2: first ID read returns 5, second correct → one done pulse, retries=1, id_ok=1.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared types and constants for the system-ID boot checker.
//   state_e          - checker FSM encoding (IDLE=0 .. REPORT=4, 3 bits)
//   ADDR_ID/ADDR_TS  - word addresses of the system ID and build timestamp
//   DEF_EXPECTED_*   - default expected values for the two words
//   tmo_cnt_w()      - width of a counter able to hold 0..TIMEOUT_CYCLES
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    RD_TS  = 3'd2,
    CHECK  = 3'd3,
    REPORT = 3'd4
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1361149627;

  function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sysid_checker_rd.sv
// sysid_checker_rd: single-word Avalon-MM read engine with waitrequest timeout.
// A launch pulse registers avm_read=1 and the word address; the read then
// completes (ack_o) on the first cycle waitrequest is low, or gives up
// (tmo_o) on the TIMEOUT_CYCLES-th consecutive waitrequest cycle.
// Ports:
//   clock, reset_n      - clock, asynchronous active-low reset
//   launch_i, addr_i    - start a read of word addr_i (takes priority over ack/tmo)
//   avm_waitrequest_i   - slave stall
//   avm_read_o          - registered read strobe
//   avm_address_o       - registered word address
//   ack_o               - combinational: read data valid this cycle
//   tmo_o               - combinational: read aborted this cycle
module sysid_checker_rd
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic launch_i,
  input  logic addr_i,
  input  logic avm_waitrequest_i,
  output logic avm_read_o,
  output logic avm_address_o,
  output logic ack_o,
  output logic tmo_o
);

  localparam int unsigned CW = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  logic          read_q, read_d;
  logic          addr_q, addr_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  assign avm_read_o    = read_q;
  assign avm_address_o = addr_q;
  assign ack_o         = read_q && !avm_waitrequest_i;
  // Counter holds the number of stall cycles already seen, so the abort
  // fires on the stall cycle that brings the total to TIMEOUT_CYCLES.
  assign tmo_o         = read_q && avm_waitrequest_i && (wait_cnt_q == LAST_WAIT);

  always_comb begin
    read_d     = read_q;
    addr_d     = addr_q;
    wait_cnt_d = wait_cnt_q;
    if (launch_i) begin
      read_d     = 1'b1;
      addr_d     = addr_i;
      wait_cnt_d = '0;
    end else if (ack_o || tmo_o) begin
      read_d     = 1'b0;
      wait_cnt_d = '0;
    end else if (read_q && avm_waitrequest_i) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      read_q     <= read_d;
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: boot-time check of the system-ID slave over Avalon-MM.
// On start it reads word 0 (system ID) then word 1 (build timestamp),
// compares them with EXPECTED_ID/EXPECTED_TS and reports a held verdict
// with a one-cycle done pulse.
// Optional feature macro: SYSID_CHECKER_RETRY_EN (adds MAX_RETRY retries of
// a failed check and the retries output).
// Ports:
//   clock, reset_n            - clock, asynchronous active-low reset
//   start                     - one-cycle request, ignored unless idle
//   busy, done                - in progress / verdict-valid pulse
//   id_ok, ts_ok, timeout     - held verdict flags of the last check
//   id_value, ts_value        - held last captured words 0 and 1
//   avm_address, avm_read     - Avalon-MM master request (registered)
//   avm_waitrequest           - slave stall
//   avm_readdata              - zero-latency read data
//   retries (optional)        - attempts used beyond the first, saturating
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef SYSID_CHECKER_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY      = 2
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
`ifdef SYSID_CHECKER_RETRY_EN
  ,
  output logic [1:0]  retries
`endif
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic launch, launch_addr, rd_ack, rd_tmo, finish;

`ifdef SYSID_CHECKER_RETRY_EN
  logic [31:0] retry_q, retry_d;
  assign retries = (|retry_q[31:2]) ? 2'b11 : retry_q[1:0];
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

  sysid_checker_rd #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd (
    .clock             (clock),
    .reset_n           (reset_n),
    .launch_i          (launch),
    .addr_i            (launch_addr),
    .avm_waitrequest_i (avm_waitrequest),
    .avm_read_o        (avm_read),
    .avm_address_o     (avm_address),
    .ack_o             (rd_ack),
    .tmo_o             (rd_tmo)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    launch      = 1'b0;
    launch_addr = ADDR_ID;
    finish      = 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_ID;
          launch    = 1'b1;
          busy_d    = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      RD_ID: begin
        if (rd_ack) begin
          id_value_d  = avm_readdata;
          state_d     = RD_TS;
          launch      = 1'b1;
          launch_addr = ADDR_TS;
        end else if (rd_tmo) begin
          timeout_d = 1'b1;
          finish    = 1'b1;
        end
      end
      RD_TS: begin
        if (rd_ack) begin
          ts_value_d = avm_readdata;
          state_d    = CHECK;
        end else if (rd_tmo) begin
          timeout_d = 1'b1;
          finish    = 1'b1;
        end
      end
      CHECK: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TS);
        finish  = 1'b1;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Common exit of an attempt (verdict computed or read aborted): either
    // re-run the whole check or report. The failure test uses the _d flags
    // so the verdict being formed this cycle is what decides.
    if (finish) begin
`ifdef SYSID_CHECKER_RETRY_EN
      if ((timeout_d || !id_ok_d || !ts_ok_d) && (retry_q < MAX_RETRY)) begin
        retry_d   = retry_q + 32'd1;
        state_d   = RD_ID;
        launch    = 1'b1;
        id_ok_d   = 1'b0;
        ts_ok_d   = 1'b0;
        timeout_d = 1'b0;
      end else begin
`endif
        state_d = REPORT;
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
`ifdef SYSID_CHECKER_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
`ifdef SYSID_CHECKER_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: scoreboard bench for sysid_checker. Each accepted start
// pushes the expected verdict and done cycle; a monitor pops and compares on
// every done pulse. A small behavioural slave drives waitrequest/readdata.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1361149627;
  localparam int unsigned TMO    = 4;
`ifdef SYSID_CHECKER_RETRY_EN
  localparam int unsigned MAXR   = 2;
  localparam int unsigned L_MISS = 4 + 3 * MAXR;
  localparam int unsigned L_TMO  = 5 + 4 * MAXR;
  localparam logic [1:0]  R_FAIL = 2'd2;
`else
  localparam int unsigned L_MISS = 4;
  localparam int unsigned L_TMO  = 5;
  localparam logic [1:0]  R_FAIL = 2'd0;
`endif

  logic        clock, reset_n, start;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
`ifdef SYSID_CHECKER_RETRY_EN
  logic [1:0]  retries;
`endif

  sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TMO)
`ifdef SYSID_CHECKER_RETRY_EN
    ,
    .MAX_RETRY      (MAXR)
`endif
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
`ifdef SYSID_CHECKER_RETRY_EN
    ,
    .retries         (retries)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave model
  logic [31:0] id_val, ts_val;
  logic        stuck, id_bad_armed;
  int unsigned ts_stall, id_bad_at;
  int unsigned ts_cyc = 0;
  int unsigned id_accepts = 0;

  always_comb begin
    avm_waitrequest = avm_read && (stuck || (avm_address && (ts_cyc < ts_stall)));
    avm_readdata    = avm_address ? ts_val
                    : ((id_bad_armed && (id_accepts == id_bad_at)) ? 32'd5 : id_val);
  end

  always @(posedge clock) begin
    if (avm_read && avm_address) ts_cyc <= ts_cyc + 1;
    else                         ts_cyc <= 0;
    if (avm_read && !avm_address && !avm_waitrequest) id_accepts <= id_accepts + 1;
  end

  // Scoreboard
  typedef struct {
    int unsigned done_edge;
    logic        iok;
    logic        tok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic [1:0]  rtr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no pulse", cyc + 1);
      end else begin
        e = sb.pop_front();
        chk("done_edge", cyc + 1, e.done_edge);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("id_ok", {31'b0, id_ok}, {31'b0, e.iok});
        chk("ts_ok", {31'b0, ts_ok}, {31'b0, e.tok});
        chk("timeout", {31'b0, timeout}, {31'b0, e.tmo});
        chk("id_value", id_value, e.idv);
        chk("ts_value", ts_value, e.tsv);
`ifdef SYSID_CHECKER_RETRY_EN
        chk("retries", {30'b0, retries}, {30'b0, e.rtr});
`endif
      end
    end
  end

  // Pulse start for one cycle; the DUT samples it on edge cyc+1.
  task automatic issue(input int unsigned lat, input logic iok, input logic tok,
                       input logic tmo, input logic [31:0] idv, input logic [31:0] tsv,
                       input logic [1:0] rtr);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    e.done_edge = cyc + 1 + lat;
    e.iok = iok;
    e.tok = tok;
    e.tmo = tmo;
    e.idv = idv;
    e.tsv = tsv;
    e.rtr = rtr;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    for (int i = 0; i < int'(budget) && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got %0d pending verdicts after %0d cycles expected 0",
               sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin
    reset_n      = 1'b1;
    start        = 1'b0;
    stuck        = 1'b0;
    ts_stall     = 0;
    id_val       = EXP_ID;
    ts_val       = EXP_TS;
    id_bad_armed = 1'b0;
    id_bad_at    = 0;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clock);

    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_flags", {29'b0, id_ok, ts_ok, timeout}, 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);
    chk("rst_avm", {30'b0, avm_read, avm_address}, 32'd0);

    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Zero-wait, both words correct
    issue(4, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 2'd0);
    wait_done(30);

    // Timestamp off by one
    ts_val = EXP_TS + 32'd1;
    issue(L_MISS, 1'b1, 1'b0, 1'b0, EXP_ID, EXP_TS + 32'd1, R_FAIL);
    wait_done(40);

    // Three waitrequest cycles on word 1 (one short of the timeout)
    ts_val   = EXP_TS;
    ts_stall = 3;
    issue(7, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 2'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("stall_addr", {31'b0, avm_address}, 32'd1);
      chk("stall_read", {31'b0, avm_read}, 32'd1);
    end
    wait_done(30);
    ts_stall = 0;

    // Wrong system ID
    id_val = 32'h1234_5678;
    issue(L_MISS, 1'b0, 1'b1, 1'b0, 32'h1234_5678, EXP_TS, R_FAIL);
    wait_done(40);

    // Stuck waitrequest: abort, uncaptured words keep previous contents,
    // and a start while busy is dropped
    id_val = EXP_ID;
    stuck  = 1'b1;
    issue(L_TMO, 1'b0, 1'b0, 1'b1, 32'h1234_5678, EXP_TS, R_FAIL);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_during_read", {31'b0, busy}, 32'd1);
    wait_done(60);
    stuck = 1'b0;
    repeat (4) @(negedge clock);

    // Reset while reading word 1
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("pre_rst_rd_ts", {30'b0, avm_read, avm_address}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_avm", {30'b0, avm_read, avm_address}, 32'd0);
    chk("mid_rst_busy_done", {30'b0, busy, done}, 32'd0);
    chk("mid_rst_flags", {29'b0, id_ok, ts_ok, timeout}, 32'd0);
    chk("mid_rst_ts_value", ts_value, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Fresh check after reset
    issue(4, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 2'd0);
    wait_done(30);

`ifdef SYSID_CHECKER_RETRY_EN
    // First ID read returns 5, the retry reads the correct value
    id_bad_armed = 1'b1;
    id_bad_at    = id_accepts;
    issue(7, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 2'd1);
    wait_done(30);
    id_bad_armed = 1'b0;
`endif

    repeat (6) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
